tt_sweep_checker: RTL

- Clocked harness that sits directly around the 4-input truth-table gate netlists (e.g. function 0x3A17).
- Upstream role: drives the gate's four inputs through all 16 vectors, holding each vector for a settle window.
- Downstream role: samples the gate's single output after each settle window and assembles the measured 16-bit truth table.
- Compares the measured table against the expected function and reports pass/fail plus a mismatch count.

---
 rtl/tt_sweep_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps a 4-input gate through all 16 vectors, captures its truth table and compares it to EXPECTED_TT.
// Optional output-stability monitor enabled by defining TT_SWEEP_STABILITY_EN.
module tt_sweep_checker #(
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [15:0] EXPECTED_TT   = 16'h3A17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_captured,
  output logic        pass,
  output logic [4:0]  mismatch_count,
  output logic        unstable
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   tt_q, tt_d;
  logic [4:0]    mm_q, mm_d;
  logic          pass_q, pass_d;
  logic          unst;
  logic          accept;
  assign accept = (state_q == IDLE) && start;
`ifdef TT_SWEEP_STABILITY_EN
  logic prev_q, unst_q, unst_d;
  // prev_q ends up holding the output seen in the last settle cycle of the vector
  assign unst_d = accept ? 1'b0 : unst_q | ((state_q == SAMPLE) && (dut_out != prev_q));
  assign unst   = unst_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      unst_q <= 1'b0;
    end else begin
      prev_q <= (state_q == SETTLE) ? dut_out : prev_q;
      unst_q <= unst_d;
    end
  end
`else
  assign unst = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        vec_d   = 4'd0;
        cnt_d   = RELOAD;
        tt_d    = 16'h0;
        mm_d    = 5'd0;
        pass_d  = 1'b0;
      end
      SETTLE: begin
        state_d = (cnt_q == '0) ? SAMPLE : SETTLE;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      SAMPLE: begin
        tt_d    = {tt_q[14:0], dut_out};
        mm_d    = (dut_out != EXPECTED_TT[4'd15 - vec_q]) ? mm_q + 5'd1 : mm_q;
        state_d = (vec_q == 4'd15) ? DONE : SETTLE;
        vec_d   = (vec_q == 4'd15) ? vec_q : vec_q + 4'd1;
        cnt_d   = RELOAD;
      end
      DONE: begin
        pass_d  = (tt_q == EXPECTED_TT) && !unst;
        vec_d   = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= '0;
      tt_q    <= 16'h0;
      mm_q    <= 5'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
    end
  end
  assign dut_in         = vec_q;
  assign busy           = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done           = (state_q == DONE);
  assign tt_captured    = tt_q;
  assign pass           = pass_q;
  assign mismatch_count = mm_q;
  assign unstable       = unst;
endmodule
